mem_port_arbiter: RTL and testbench

Two-client arbiter sharing the single main-memory port between the L1 instruction cache and the L1 data cache. It uses the existing cache/memory handshake unchanged: VALID/READY connect, address with ACK_ADDR, a per-word ACK_DATA index, and RESET_ACK. The arbiter sits between both L1 blocks and the memory model. It grants one whole transaction (an 8-word line fill or a 1-word store) at a time, with round-robin fairness, and multiplexes every handshake signal.

---
 rtl/mem_if_pkg.sv | 38 +++
 rtl/rr_pick.sv | 19 +
 rtl/mem_port_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared cache/memory handshake definitions for the L1I, L1D and the memory-port arbiter.
// Pure types and constants; no timing or flow control of its own.
package mem_if_pkg;

  localparam int         BUS_W          = 32;
  localparam logic [3:0] ACK_IDLE       = 4'b1111;
  localparam int         WORDS_PER_LINE = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } arb_state_t;

  // Client-to-memory request channel, in port order.
  typedef struct packed {
    logic             vld;
    logic [BUS_W-1:0] dat;
    logic             ack_addr;
    logic [3:0]       ack_data;
    logic             reset_ack;
  } l1_req_t;

  // Memory-to-client response channel, in port order.
  typedef struct packed {
    logic             rdy;
    logic [BUS_W-1:0] dat;
    logic             ack_addr;
    logic [3:0]       ack_data;
    logic             reset_ack;
  } mem_rsp_t;

  localparam l1_req_t REQ_PARK = '{vld: 1'b0, dat: '0, ack_addr: 1'b0,
                                   ack_data: ACK_IDLE, reset_ack: 1'b0};
  localparam mem_rsp_t RSP_PARK = '{rdy: 1'b0, dat: '0, ack_addr: 1'b0,
                                    ack_data: ACK_IDLE, reset_ack: 1'b0};

endpackage

// File: rtl/rr_pick.sv
// Combinational 2-way round-robin selector: bit 0 = I, bit 1 = D; on a tie the client not served last wins.
// Zero latency; no backpressure of its own.
module rr_pick (
  input  logic [1:0] req_i,
  input  logic       last_d_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = last_d_i ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Grants the single memory port to the L1I or L1D for a whole transaction; grant 1 cycle after request, zero-latency forwarding.
// A waiting client is held off by seeing READY=0 and idle acks until its turn; grants are never revoked.
module mem_port_arbiter
  import mem_if_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             I_VALID,
  input  logic             D_VALID,
  input  logic [BUS_W-1:0] I_DATA,
  input  logic [BUS_W-1:0] D_DATA,
  input  logic             I_ACK_ADDR,
  input  logic             D_ACK_ADDR,
  input  logic [3:0]       I_ACK_DATA,
  input  logic [3:0]       D_ACK_DATA,
  input  logic             I_RESET_ACK,
  input  logic             D_RESET_ACK,
  output logic             I_READY,
  output logic             D_READY,
  output logic [BUS_W-1:0] I_DATA_MEM,
  output logic [BUS_W-1:0] D_DATA_MEM,
  output logic             I_ACK_ADDR_MEM,
  output logic             D_ACK_ADDR_MEM,
  output logic [3:0]       I_ACK_DATA_MEM,
  output logic [3:0]       D_ACK_DATA_MEM,
  output logic             I_RESET_ACK_MEM,
  output logic             D_RESET_ACK_MEM,
  output logic             VALID,
  output logic [BUS_W-1:0] DATA_L1,
  output logic             ACK_ADDR_L1,
  output logic [3:0]       ACK_DATA_L1,
  output logic             RESET_ACK_L1,
  input  logic             READY,
  input  logic [BUS_W-1:0] DATA_MEM,
  input  logic             ACK_ADDR_MEM,
  input  logic [3:0]       ACK_DATA_MEM,
  input  logic             RESET_ACK_MEM,
  output logic [1:0]       grant,
  output logic             timeout_err
);

  localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT);

  arb_state_t  state_q, state_d;
  logic        last_d_q, last_d_d;   // 1 = D was served last
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [1:0]  pick;

  rr_pick u_rr_pick (
    .req_i    ({D_VALID, I_VALID}),
    .last_d_i (last_d_q),
    .gnt_o    (pick)
  );

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pick[1])      state_d = GNT_D;
        else if (pick[0]) state_d = GNT_I;
      end
      GNT_I, GNT_D: begin
        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
        if (cnt_d == CNT_LIMIT) err_d = 1'b1;
        if (state_q == GNT_I && !I_VALID) begin
          state_d  = IDLE;
          last_d_d = 1'b0;
        end
        if (state_q == GNT_D && !D_VALID) begin
          state_d  = IDLE;
          last_d_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Forwarding is purely combinational off the registered grant.
  logic     gnt_i, gnt_d;
  l1_req_t  i_req, d_req, mem_req;
  mem_rsp_t mem_rsp, i_rsp, d_rsp;

  assign gnt_i = (state_q == GNT_I);
  assign gnt_d = (state_q == GNT_D);

  assign i_req   = '{vld: I_VALID, dat: I_DATA, ack_addr: I_ACK_ADDR,
                     ack_data: I_ACK_DATA, reset_ack: I_RESET_ACK};
  assign d_req   = '{vld: D_VALID, dat: D_DATA, ack_addr: D_ACK_ADDR,
                     ack_data: D_ACK_DATA, reset_ack: D_RESET_ACK};
  assign mem_rsp = '{rdy: READY, dat: DATA_MEM, ack_addr: ACK_ADDR_MEM,
                     ack_data: ACK_DATA_MEM, reset_ack: RESET_ACK_MEM};

  assign mem_req = gnt_i ? i_req : (gnt_d ? d_req : REQ_PARK);
  assign i_rsp   = gnt_i ? mem_rsp : RSP_PARK;
  assign d_rsp   = gnt_d ? mem_rsp : RSP_PARK;

  assign {VALID, DATA_L1, ACK_ADDR_L1, ACK_DATA_L1, RESET_ACK_L1} = mem_req;
  assign {I_READY, I_DATA_MEM, I_ACK_ADDR_MEM, I_ACK_DATA_MEM, I_RESET_ACK_MEM} = i_rsp;
  assign {D_READY, D_DATA_MEM, D_ACK_ADDR_MEM, D_ACK_DATA_MEM, D_RESET_ACK_MEM} = d_rsp;

  assign grant       = {gnt_d, gnt_i};
  assign timeout_err = err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: an ownership model checks every output each cycle,
// and literal expectations pin latency, fairness, park values, timeout and reset behaviour.
module tb_mem_port_arbiter;

  localparam int TIMEOUT = 64;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        I_VALID, D_VALID;
  logic [31:0] I_DATA, D_DATA;
  logic        I_ACK_ADDR, D_ACK_ADDR;
  logic [3:0]  I_ACK_DATA, D_ACK_DATA;
  logic        I_RESET_ACK, D_RESET_ACK;
  logic        I_READY, D_READY;
  logic [31:0] I_DATA_MEM, D_DATA_MEM;
  logic        I_ACK_ADDR_MEM, D_ACK_ADDR_MEM;
  logic [3:0]  I_ACK_DATA_MEM, D_ACK_DATA_MEM;
  logic        I_RESET_ACK_MEM, D_RESET_ACK_MEM;
  logic        VALID;
  logic [31:0] DATA_L1;
  logic        ACK_ADDR_L1;
  logic [3:0]  ACK_DATA_L1;
  logic        RESET_ACK_L1;
  logic        READY;
  logic [31:0] DATA_MEM;
  logic        ACK_ADDR_MEM;
  logic [3:0]  ACK_DATA_MEM;
  logic        RESET_ACK_MEM;
  logic [1:0]  grant;
  logic        timeout_err;

  mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_VALID(I_VALID), .D_VALID(D_VALID),
    .I_DATA(I_DATA), .D_DATA(D_DATA),
    .I_ACK_ADDR(I_ACK_ADDR), .D_ACK_ADDR(D_ACK_ADDR),
    .I_ACK_DATA(I_ACK_DATA), .D_ACK_DATA(D_ACK_DATA),
    .I_RESET_ACK(I_RESET_ACK), .D_RESET_ACK(D_RESET_ACK),
    .I_READY(I_READY), .D_READY(D_READY),
    .I_DATA_MEM(I_DATA_MEM), .D_DATA_MEM(D_DATA_MEM),
    .I_ACK_ADDR_MEM(I_ACK_ADDR_MEM), .D_ACK_ADDR_MEM(D_ACK_ADDR_MEM),
    .I_ACK_DATA_MEM(I_ACK_DATA_MEM), .D_ACK_DATA_MEM(D_ACK_DATA_MEM),
    .I_RESET_ACK_MEM(I_RESET_ACK_MEM), .D_RESET_ACK_MEM(D_RESET_ACK_MEM),
    .VALID(VALID), .DATA_L1(DATA_L1), .ACK_ADDR_L1(ACK_ADDR_L1),
    .ACK_DATA_L1(ACK_DATA_L1), .RESET_ACK_L1(RESET_ACK_L1),
    .READY(READY), .DATA_MEM(DATA_MEM), .ACK_ADDR_MEM(ACK_ADDR_MEM),
    .ACK_DATA_MEM(ACK_DATA_MEM), .RESET_ACK_MEM(RESET_ACK_MEM),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  // Ownership model: who holds the port, who was served last, how long the grant has lasted.
  int owner = 0;       // 0 none, 1 I, 2 D
  bit last_was_d = 1'b0;
  int hold = 0;
  bit m_err = 1'b0;

  always @(posedge CLK) begin
    if (RESET) begin
      owner = 0; last_was_d = 1'b0; hold = 0; m_err = 1'b0;
    end else if (owner == 0) begin
      hold = 0;
      if (I_VALID && D_VALID) owner = last_was_d ? 1 : 2;
      else if (D_VALID)       owner = 2;
      else if (I_VALID)       owner = 1;
    end else begin
      hold++;
      if (hold >= TIMEOUT) m_err = 1'b1;
      if (owner == 1 && !I_VALID) begin owner = 0; last_was_d = 1'b0; end
      else if (owner == 2 && !D_VALID) begin owner = 0; last_was_d = 1'b1; end
    end
  end

  always @(negedge CLK) begin
    if (cmp_en) begin
      logic [38:0] park_req, park_rsp, rsp, exp_mem, exp_i, exp_d;
      park_req = {1'b0, 32'h0, 1'b0, 4'hF, 1'b0};
      park_rsp = {1'b0, 32'h0, 1'b0, 4'hF, 1'b0};
      rsp      = {READY, DATA_MEM, ACK_ADDR_MEM, ACK_DATA_MEM, RESET_ACK_MEM};
      exp_mem  = (owner == 1) ? {I_VALID, I_DATA, I_ACK_ADDR, I_ACK_DATA, I_RESET_ACK} :
                 (owner == 2) ? {D_VALID, D_DATA, D_ACK_ADDR, D_ACK_DATA, D_RESET_ACK} : park_req;
      exp_i    = (owner == 1) ? rsp : park_rsp;
      exp_d    = (owner == 2) ? rsp : park_rsp;
      chk("model_grant", grant, (owner == 1) ? 2'b01 : (owner == 2) ? 2'b10 : 2'b00);
      chk("model_timeout", timeout_err, m_err);
      chk("model_mem_side", {VALID, DATA_L1, ACK_ADDR_L1, ACK_DATA_L1, RESET_ACK_L1}, exp_mem);
      chk("model_i_side", {I_READY, I_DATA_MEM, I_ACK_ADDR_MEM, I_ACK_DATA_MEM, I_RESET_ACK_MEM}, exp_i);
      chk("model_d_side", {D_READY, D_DATA_MEM, D_ACK_ADDR_MEM, D_ACK_DATA_MEM, D_RESET_ACK_MEM}, exp_d);
    end
  end

  logic [31:0] got_line [8];

  initial begin
    RESET = 1'b1;
    I_VALID = 0; D_VALID = 0; I_DATA = 0; D_DATA = 0;
    I_ACK_ADDR = 0; D_ACK_ADDR = 0; I_ACK_DATA = 4'hF; D_ACK_DATA = 4'hF;
    I_RESET_ACK = 0; D_RESET_ACK = 0;
    READY = 0; DATA_MEM = 0; ACK_ADDR_MEM = 0; ACK_DATA_MEM = 4'hF; RESET_ACK_MEM = 0;

    nxt();
    cmp_en = 1'b1;
    nxt();
    @(negedge CLK);
    chk("rst_grant", grant, 2'b00);
    chk("rst_timeout", timeout_err, 1'b0);
    chk("rst_mem_park", {VALID, ACK_DATA_L1, DATA_L1}, {1'b0, 4'hF, 32'h0});
    chk("rst_client_park", {I_READY, I_ACK_DATA_MEM, D_READY, D_ACK_DATA_MEM}, {1'b0, 4'hF, 1'b0, 4'hF});
    nxt();
    RESET = 1'b0;

    // D alone: one-cycle grant latency, 8-word fill seen by D only.
    D_VALID = 1; D_DATA = 32'h0000_1000; D_ACK_ADDR = 1;
    @(negedge CLK);
    chk("d_req_latency", grant, 2'b00);
    nxt();
    @(negedge CLK);
    chk("d_grant", grant, 2'b10);
    chk("d_addr_fwd", DATA_L1, 32'h0000_1000);
    nxt();
    D_ACK_ADDR = 0; READY = 1; ACK_ADDR_MEM = 1;
    @(negedge CLK);
    chk("d_ack_addr_route", {D_ACK_ADDR_MEM, I_ACK_ADDR_MEM}, 2'b10);
    for (int k = 0; k < 8; k++) begin
      nxt();
      ACK_ADDR_MEM = 0; DATA_MEM = 32'hD0D0_0000 + k; ACK_DATA_MEM = 4'(k); D_ACK_DATA = 4'(k);
      @(negedge CLK);
      chk("d_fill_idx", D_ACK_DATA_MEM, k);
      chk("d_fill_data", D_DATA_MEM, 32'hD0D0_0000 + k);
      chk("d_fill_i_idle", {I_ACK_DATA_MEM, I_DATA_MEM}, {4'hF, 32'h0});
    end
    nxt();
    READY = 0; ACK_DATA_MEM = 4'hF; DATA_MEM = 0; D_ACK_DATA = 4'hF; D_VALID = 0;
    @(negedge CLK);
    chk("d_release_valid", VALID, 1'b0);
    nxt();
    @(negedge CLK);
    chk("d_release_idle", grant, 2'b00);

    // Tie after reset: D first, I held pending, one IDLE cycle, then I fills its line.
    nxt();
    RESET = 1;
    nxt();
    RESET = 0;
    I_VALID = 1; D_VALID = 1; I_DATA = 32'h0000_2000; D_DATA = 32'hCAFE_0001;
    nxt();
    @(negedge CLK);
    chk("tie_d_first", grant, 2'b10);
    nxt();
    READY = 1; ACK_DATA_MEM = 4'h0; D_ACK_DATA = 4'h0;
    @(negedge CLK);
    chk("store_i_blocked", I_READY, 1'b0);
    chk("store_d_ready", D_READY, 1'b1);
    chk("store_data_fwd", DATA_L1, 32'hCAFE_0001);
    nxt();
    READY = 0; ACK_DATA_MEM = 4'hF; D_ACK_DATA = 4'hF; D_VALID = 0;
    @(negedge CLK);
    chk("store_release_hold", grant, 2'b10);
    nxt();
    @(negedge CLK);
    chk("turnaround_idle", grant, 2'b00);
    chk("turnaround_mem_valid", VALID, 1'b0);
    nxt();
    @(negedge CLK);
    chk("i_after_d", grant, 2'b01);
    chk("i_addr_fwd", DATA_L1, 32'h0000_2000);
    for (int k = 0; k < 8; k++) begin
      nxt();
      READY = 1; DATA_MEM = 32'hA5A5_0000 + 32'(k) * 32'h11; ACK_DATA_MEM = 4'(k); I_ACK_DATA = 4'(k);
      @(negedge CLK);
      got_line[k] = I_DATA_MEM;
      chk("i_fill_d_idle", D_ACK_DATA_MEM, 4'hF);
    end
    for (int k = 0; k < 8; k++) chk("i_line_word", got_line[k], 32'hA5A5_0000 + 32'(k) * 32'h11);
    nxt();
    READY = 0; ACK_DATA_MEM = 4'hF; DATA_MEM = 0; I_ACK_DATA = 4'hF; I_VALID = 0;

    // Hold D for more than TIMEOUT cycles: error appears after the 64th grant cycle and sticks.
    nxt();
    D_VALID = 1; D_DATA = 32'h0000_3000;
    nxt();
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(negedge CLK);
      chk("timeout_not_yet", timeout_err, 1'b0);
      nxt();
    end
    @(negedge CLK);
    chk("timeout_set", timeout_err, 1'b1);
    chk("timeout_no_revoke", grant, 2'b10);
    nxt();
    D_VALID = 0;
    nxt();
    nxt();
    @(negedge CLK);
    chk("timeout_sticky", timeout_err, 1'b1);
    chk("timeout_idle", grant, 2'b00);

    // Reset in the middle of an I fill, then a fresh fill.
    nxt();
    RESET = 1;
    nxt();
    RESET = 0;
    @(negedge CLK);
    chk("timeout_cleared", timeout_err, 1'b0);
    I_VALID = 1; I_DATA = 32'h0000_4000;
    nxt();
    @(negedge CLK);
    chk("i_grant", grant, 2'b01);
    for (int k = 0; k < 4; k++) begin
      nxt();
      READY = 1; DATA_MEM = 32'h5000_0000 + k; ACK_DATA_MEM = 4'(k); I_ACK_DATA = 4'(k);
      @(negedge CLK);
      chk("pre_reset_idx", I_ACK_DATA_MEM, k);
    end
    nxt();
    RESET = 1;
    nxt();
    @(negedge CLK);
    chk("midfill_rst_valid", VALID, 1'b0);
    chk("midfill_rst_ack", ACK_DATA_L1, 4'hF);
    chk("midfill_rst_grant", grant, 2'b00);
    chk("midfill_rst_i_park", {I_READY, I_ACK_DATA_MEM}, {1'b0, 4'hF});
    nxt();
    RESET = 0; READY = 0; ACK_DATA_MEM = 4'hF; DATA_MEM = 0; I_ACK_DATA = 4'hF;
    nxt();
    @(negedge CLK);
    chk("post_rst_grant", grant, 2'b01);
    for (int k = 0; k < 8; k++) begin
      nxt();
      READY = 1; DATA_MEM = 32'h6000_0000 + k; ACK_DATA_MEM = 4'(k); I_ACK_DATA = 4'(k);
      @(negedge CLK);
      chk("post_rst_fill", {I_ACK_DATA_MEM, I_DATA_MEM}, {4'(k), 32'h6000_0000 + k});
    end
    nxt();
    READY = 0; ACK_DATA_MEM = 4'hF; DATA_MEM = 0; I_ACK_DATA = 4'hF; I_VALID = 0;
    nxt();
    nxt();
    @(negedge CLK);
    chk("final_idle", {grant, VALID, ACK_DATA_L1}, {2'b00, 1'b0, 4'hF});

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
